sysref_phase_tracker: RTL

// Consumes user_sysref_adc (ADC AXI clock domain, produced by the SYSREF sync stage).

---
 rtl/sysref_phase_tracker_pkg.sv | 7 +
 rtl/sysref_interval_meter.sv | 26 ++
 rtl/sysref_phase_tracker.sv | 97 +++++++++
 3 files changed

// File: rtl/sysref_phase_tracker_pkg.sv
// sysref_phase_tracker_pkg: tracker state encodings and default counter width.
package sysref_phase_tracker_pkg;
  localparam int DEFAULT_COUNTER_WIDTH = 8;
  localparam logic [1:0] SEARCH  = 2'b00;
  localparam logic [1:0] ACQUIRE = 2'b01;
  localparam logic [1:0] LOCKED  = 2'b10;
endpackage

// File: rtl/sysref_interval_meter.sv
// sysref_interval_meter: SYSREF rising-edge detect with a saturating interval counter.
module sysref_interval_meter import sysref_phase_tracker_pkg::*; #(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     adcClk,
  input  logic                     adcResetN,
  input  logic                     sysref,
  output logic                     sysrefEdge,
  output logic [COUNTER_WIDTH-1:0] measCnt,
  output logic [COUNTER_WIDTH-1:0] lastInterval,
  output logic                     saturated
);
  logic sysrefPrev;
  assign sysrefEdge = sysref & ~sysrefPrev;
  assign saturated = &measCnt;
  always_ff @(posedge adcClk or negedge adcResetN)
    if (!adcResetN) begin
      sysrefPrev <= 1'b1;  // SYSREF already high at reset release is not an edge
      measCnt <= '0;
      lastInterval <= '0;
    end else begin
      sysrefPrev <= sysref;
      measCnt <= sysrefEdge ? '0 : saturated ? measCnt : measCnt + 1'b1;
      lastInterval <= sysrefEdge ? measCnt : lastInterval;
    end
endmodule

// File: rtl/sysref_phase_tracker.sv
// sysref_phase_tracker: locks a free-running phase counter to the SYSREF interval and flags slips.
module sysref_phase_tracker import sysref_phase_tracker_pkg::*; #(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_WIDTH = 8
) (
  input  logic                     adcClk,
  input  logic                     adcResetN,
  input  logic                     user_sysref_adc,
  input  logic [COUNTER_WIDTH-1:0] expectedPeriodM1,
  input  logic                     autoRelock,
  input  logic                     relock,
  input  logic                     clearErrors,
  output logic                     sysrefTick,
  output logic [COUNTER_WIDTH-1:0] phase,
  output logic                     locked,
  output logic [1:0]               state,
  output logic [COUNTER_WIDTH-1:0] lastInterval,
  output logic [ERR_WIDTH-1:0]     mismatchCount
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  logic sysrefEdge, saturated, wrap, mismatch, goodHit, tickNext;
  logic [COUNTER_WIDTH-1:0] measCnt, periodLatched, periodNext, phaseNext;
  logic [GW-1:0] goodCount, goodNext;
  logic [1:0] stateNext;
  logic [ERR_WIDTH-1:0] errNext;
  sysref_interval_meter #(.COUNTER_WIDTH(COUNTER_WIDTH)) meter (
    .adcClk(adcClk),
    .adcResetN(adcResetN),
    .sysref(user_sysref_adc),
    .sysrefEdge(sysrefEdge),
    .measCnt(measCnt),
    .lastInterval(lastInterval),
    .saturated(saturated)
  );
  assign wrap = phase == periodLatched;
  assign goodHit = measCnt == expectedPeriodM1;
  // An edge is only on time in the cycle the phase sits at its wrap point
  assign mismatch = state == LOCKED && sysrefEdge && !wrap && !relock;
  assign errNext = clearErrors ? '0 : (mismatch && !(&mismatchCount)) ? mismatchCount + 1'b1 : mismatchCount;
  always_comb begin
    stateNext = state;
    goodNext = goodCount;
    phaseNext = '0;
    tickNext = 1'b0;
    periodNext = periodLatched;
    if (relock) begin
      stateNext = SEARCH;
      goodNext = '0;
    end else if (state == SEARCH) begin
      goodNext = '0;
      stateNext = (sysrefEdge && expectedPeriodM1 != '0) ? ACQUIRE : SEARCH;
    end else if (state == ACQUIRE) begin
      if (sysrefEdge) begin
        goodNext = goodHit ? goodCount + 1'b1 : '0;
        if (goodHit && goodCount == GW'(LOCK_COUNT - 1)) begin
          stateNext = LOCKED;
          goodNext = '0;
          periodNext = expectedPeriodM1;
          tickNext = 1'b1;
        end
      end else if (saturated) begin
        stateNext = SEARCH;
        goodNext = '0;
      end
    end else if (state == LOCKED) begin
      if (mismatch && autoRelock) begin
        stateNext = ACQUIRE;
        goodNext = '0;
      end else begin
        phaseNext = wrap ? '0 : phase + 1'b1;
        tickNext = wrap;
      end
    end else begin
      stateNext = SEARCH;
      goodNext = '0;
    end
  end
  always_ff @(posedge adcClk or negedge adcResetN)
    if (!adcResetN) begin
      state <= SEARCH;
      locked <= 1'b0;
      goodCount <= '0;
      phase <= '0;
      sysrefTick <= 1'b0;
      periodLatched <= '0;
      mismatchCount <= '0;
    end else begin
      state <= stateNext;
      locked <= stateNext == LOCKED;
      goodCount <= goodNext;
      phase <= phaseNext;
      sysrefTick <= tickNext;
      periodLatched <= periodNext;
      mismatchCount <= errNext;
    end
endmodule
